fifo_tx_serializer: RTL

Downstream drain stage for `hfifo`: watches the FIFO's `rdy` and pops one word at a time. Each word is shifted out on a single-bit asynchronous-style line as start bit, data LSB-first, stop bit, at a fixed clock-divided bit rate. Replaces direct LED observation of `dout` with a paced, observable serial stream. A saturating-free wrap counter reports frames sent.

---
 rtl/fifo_tx_serializer.sv | 100 ++++++++++
 1 files changed

// File: rtl/fifo_tx_serializer.sv
// Drain stage for a first-word-fall-through FIFO: pops one word at a time and
// shifts it out on txd as start bit, data LSB-first, stop bit at DIV clocks per bit.
module fifo_tx_serializer #(
  parameter int WIDTH = 4,
  parameter int DIV   = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rdy,
  input  logic [WIDTH-1:0] din,
  output logic             pop,
  output logic             txd,
  output logic             busy,
  output logic [7:0]       sent_count
);

  // state   | meaning
  // S_IDLE  | line high, waiting for rdy
  // S_START | start bit (txd=0)
  // S_DATA  | data bits, LSB first
  // S_STOP  | stop bit (txd=1), frame counted at its end
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [IW-1:0] B_LAST = IW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_next;
  logic [TW-1:0]    timer;
  logic [IW-1:0]    bit_idx;
  logic             bit_end;

  assign bit_end = (timer == T_LAST);
  assign sh_next = shreg >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      shreg      <= '0;
      timer      <= '0;
      bit_idx    <= '0;
      pop        <= 1'b0;
      txd        <= 1'b1;
      busy       <= 1'b0;
      sent_count <= 8'd0;
    end else begin
      pop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rdy) begin
            shreg <= din;
            pop   <= 1'b1;
            state <= S_START;
            txd   <= 1'b0;
            busy  <= 1'b1;
            timer <= '0;
          end
        end
        S_START: begin
          timer <= bit_end ? '0 : timer + TW'(1);
          if (bit_end) begin
            state   <= S_DATA;
            txd     <= shreg[0];
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          timer <= bit_end ? '0 : timer + TW'(1);
          if (bit_end) begin
            if (bit_idx == B_LAST) begin
              state <= S_STOP;
              txd   <= 1'b1;
            end else begin
              // shift so the next bit is always at position 0
              shreg   <= sh_next;
              txd     <= sh_next[0];
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        S_STOP: begin
          timer <= bit_end ? '0 : timer + TW'(1);
          if (bit_end) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            sent_count <= sent_count + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
